umi_packet_merge_timed: RTL and testbench

Parametrised greedy UMI packet merger with a configurable output width, an idle-timeout flush, an external flush, and a merge-disable mode. It sits between a narrow UMI source (IDW) and a wide UMI sink (ODW = N·IDW). It coalesces address-contiguous, field-compatible packets into one wider packet, and guarantees forward progress when the input stream stalls.

---
 rtl/umi_packet_merge_timed_pkg.sv | 62 ++++++
 rtl/umi_merge_timer.sv | 30 +++
 rtl/umi_packet_merge_timed.sv | 168 ++++++++++++++++
 tb/tb_umi_packet_merge_timed.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/umi_packet_merge_timed_pkg.sv
// Shared types and UMI command helpers for the timed packet merger.
// Command layout: opcode[4:0] size[7:5] len[15:8] eom[22] ex[24].
package umi_packet_merge_timed_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } merge_state_t;

    localparam logic [4:0] UMI_REQ_READ   = 5'h01;
    localparam logic [4:0] UMI_RESP_READ  = 5'h02;
    localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
    localparam logic [4:0] UMI_RESP_WRITE = 5'h04;
    localparam logic [4:0] UMI_REQ_POSTED = 5'h05;
    localparam logic [4:0] UMI_REQ_RDMA   = 5'h07;

    // Fields that must match to merge: all but len/atype, eom and ex
    localparam logic [31:0] UMI_MATCH_MASK = 32'hFEBF_00FF;

    function automatic logic umi_decode_merge(input logic [4:0] op);
        return op inside {UMI_REQ_READ, UMI_REQ_WRITE, UMI_REQ_POSTED,
                          UMI_REQ_RDMA, UMI_RESP_READ, UMI_RESP_WRITE};
    endfunction

    function automatic logic [4:0] umi_unpack_opcode(input logic [31:0] cmd);
        return cmd[4:0];
    endfunction

    function automatic logic [2:0] umi_unpack_size(input logic [31:0] cmd);
        return cmd[7:5];
    endfunction

    function automatic logic [7:0] umi_unpack_len(input logic [31:0] cmd);
        return cmd[15:8];
    endfunction

    function automatic logic umi_unpack_eom(input logic [31:0] cmd);
        return cmd[22];
    endfunction

    function automatic logic umi_unpack_ex(input logic [31:0] cmd);
        return cmd[24];
    endfunction

    function automatic logic [7:0] umi_bytes(input logic [31:0] cmd);
        logic [7:0] unit;
        unit = 8'd1 << umi_unpack_size(cmd);
        return 8'(unit * (umi_unpack_len(cmd) + 8'd1));
    endfunction

    function automatic logic [31:0] umi_pack_len(input logic [31:0] cmd,
                                                 input logic [7:0]  len);
        return {cmd[31:16], len, cmd[7:0]};
    endfunction

    function automatic logic [31:0] umi_pack_join(input logic [31:0] acc,
                                                  input logic [31:0] cmd);
        return {acc[31:23], cmd[22], acc[21:16], cmd[15:8], acc[7:0]};
    endfunction

endpackage

// File: rtl/umi_merge_timer.sv
// Idle timeout counter for the packet merger.
// expire fires on the idle cycle that completes TIMEOUT idle cycles.
module umi_merge_timer #(
    parameter int TIMEOUT = 16,
    parameter int TW      = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && cnt_q != LIMIT) begin
            cnt_q <= cnt_q + TW'(1);
        end
    end

    assign expire = (TIMEOUT != 0) && (cnt_q + TW'(1) == LIMIT);

endmodule

// File: rtl/umi_packet_merge_timed.sv
// Greedy UMI packet merger: narrow IDW stream into N*IDW packets,
// with idle-timeout flush, external flush and merge disable.
module umi_packet_merge_timed
    import umi_packet_merge_timed_pkg::*;
#(
    parameter int CW      = 32,
    parameter int AW      = 64,
    parameter int IDW     = 64,
    parameter int N       = 4,
    parameter int TIMEOUT = 16,
    parameter int TW      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             merge_en,
    input  logic             flush,
    input  logic             umi_in_valid,
    output logic             umi_in_ready,
    input  logic [CW-1:0]    umi_in_cmd,
    input  logic [AW-1:0]    umi_in_dstaddr,
    input  logic [AW-1:0]    umi_in_srcaddr,
    input  logic [IDW-1:0]   umi_in_data,
    output logic             umi_out_valid,
    input  logic             umi_out_ready,
    output logic [CW-1:0]    umi_out_cmd,
    output logic [AW-1:0]    umi_out_dstaddr,
    output logic [AW-1:0]    umi_out_srcaddr,
    output logic [N*IDW-1:0] umi_out_data,
    output logic             busy
);

    localparam int ODW = N * IDW;
    localparam logic [8:0] MAXB = 9'(ODW / 8);

    merge_state_t state_q, state_d;
    logic [CW-1:0]  cmd_q;
    logic [AW-1:0]  dst_q, src_q, next_dst_q, next_src_q;
    logic [ODW-1:0] data_q;
    logic [8:0]     count_q;
    logic [1:0]     init_q;

    logic [7:0]     in_bytes;
    logic [AW-1:0]  in_step;
    logic [8:0]     sum;
    logic [8:0]     off_bytes;
    logic [IDW-1:0] in_mask;
    logic [ODW-1:0] in_wide, in_shift;
    logic           compat, fresh_close, join_close;
    logic           accept, timer_en, timer_clear, expire;
    logic           emit;
    logic [7:0]     out_len;

    assign in_bytes  = umi_bytes(umi_in_cmd);
    assign in_step   = {{(AW-8){1'b0}}, in_bytes};
    assign sum       = count_q + {1'b0, in_bytes};
    assign off_bytes = (state_q == ACCUM) ? count_q : 9'd0;
    assign in_mask   = ~({IDW{1'b1}} << {in_bytes, 3'b000});
    assign in_wide   = {{(ODW-IDW){1'b0}}, umi_in_data & in_mask};
    assign in_shift  = in_wide << {off_bytes, 3'b000};

    assign compat = (((umi_in_cmd ^ cmd_q) & UMI_MATCH_MASK) == '0)
                  && !umi_unpack_ex(umi_in_cmd)
                  && umi_in_dstaddr == next_dst_q
                  && umi_in_srcaddr == next_src_q
                  && sum <= MAXB
                  && merge_en;

    assign fresh_close = !merge_en
                       || !umi_decode_merge(umi_unpack_opcode(umi_in_cmd))
                       || umi_unpack_ex(umi_in_cmd)
                       || umi_unpack_eom(umi_in_cmd)
                       || {1'b0, in_bytes} == MAXB;

    assign join_close = umi_unpack_eom(umi_in_cmd) || sum == MAXB;

    always_comb begin
        state_d      = state_q;
        umi_in_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                umi_in_ready = init_q[1];
            end
            ACCUM: begin
                umi_in_ready = init_q[1] && compat && !flush && !expire;
            end
            EMIT: begin
                umi_in_ready = init_q[1] && umi_out_ready;
            end
            default: begin
                umi_in_ready = 1'b0;
            end
        endcase
        accept      = umi_in_valid && umi_in_ready;
        timer_en    = (state_q == ACCUM) && !accept;
        timer_clear = (state_q != ACCUM) || accept;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = fresh_close ? EMIT : ACCUM;
            end
            ACCUM: begin
                // a held incompatible input forces the emit, then reloads
                if (accept) state_d = join_close ? EMIT : ACCUM;
                else if (flush || expire || umi_in_valid) state_d = EMIT;
            end
            EMIT: begin
                if (umi_out_ready) begin
                    if (accept) state_d = fresh_close ? EMIT : ACCUM;
                    else state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    umi_merge_timer #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_en),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            init_q     <= '0;
            cmd_q      <= '0;
            dst_q      <= '0;
            src_q      <= '0;
            next_dst_q <= '0;
            next_src_q <= '0;
            data_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q <= state_d;
            init_q  <= {init_q[0], 1'b1};
            if (accept && state_q != ACCUM) begin
                cmd_q      <= umi_in_cmd;
                dst_q      <= umi_in_dstaddr;
                src_q      <= umi_in_srcaddr;
                next_dst_q <= umi_in_dstaddr + in_step;
                next_src_q <= umi_in_srcaddr + in_step;
                data_q     <= in_shift;
                count_q    <= {1'b0, in_bytes};
            end else if (accept) begin
                cmd_q      <= umi_pack_join(cmd_q, umi_in_cmd);
                next_dst_q <= next_dst_q + in_step;
                next_src_q <= next_src_q + in_step;
                data_q     <= data_q | in_shift;
                count_q    <= sum;
            end
        end
    end

    assign emit    = (state_q == EMIT);
    assign out_len = 8'((count_q >> umi_unpack_size(cmd_q)) - 9'd1);

    assign umi_out_valid   = emit;
    assign umi_out_cmd     = emit ? umi_pack_len(cmd_q, out_len) : '0;
    assign umi_out_dstaddr = emit ? dst_q : '0;
    assign umi_out_srcaddr = emit ? src_q : '0;
    assign umi_out_data    = emit ? data_q : '0;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_umi_packet_merge_timed.sv
// Directed scoreboard bench for umi_packet_merge_timed
// (IDW=64, N=4, TIMEOUT=16).
module tb_umi_packet_merge_timed;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         merge_en = 1'b1;
    logic         flush = 1'b0;
    logic         umi_in_valid = 1'b0;
    logic         umi_in_ready;
    logic [31:0]  umi_in_cmd = '0;
    logic [63:0]  umi_in_dstaddr = '0;
    logic [63:0]  umi_in_srcaddr = '0;
    logic [63:0]  umi_in_data = '0;
    logic         umi_out_valid;
    logic         umi_out_ready = 1'b1;
    logic [31:0]  umi_out_cmd;
    logic [63:0]  umi_out_dstaddr;
    logic [63:0]  umi_out_srcaddr;
    logic [255:0] umi_out_data;
    logic         busy;

    int checks = 0;
    int fails  = 0;
    bit stall_on = 1'b0;
    int stalls = 0;

    typedef struct {
        logic [31:0]  cmd;
        logic [63:0]  dst;
        logic [63:0]  src;
        logic [255:0] data;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    umi_packet_merge_timed #(
        .CW(32), .AW(64), .IDW(64), .N(4), .TIMEOUT(16), .TW(8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .merge_en        (merge_en),
        .flush           (flush),
        .umi_in_valid    (umi_in_valid),
        .umi_in_ready    (umi_in_ready),
        .umi_in_cmd      (umi_in_cmd),
        .umi_in_dstaddr  (umi_in_dstaddr),
        .umi_in_srcaddr  (umi_in_srcaddr),
        .umi_in_data     (umi_in_data),
        .umi_out_valid   (umi_out_valid),
        .umi_out_ready   (umi_out_ready),
        .umi_out_cmd     (umi_out_cmd),
        .umi_out_dstaddr (umi_out_dstaddr),
        .umi_out_srcaddr (umi_out_srcaddr),
        .umi_out_data    (umi_out_data),
        .busy            (busy)
    );

    // hostid=3, qos=2 so field matching sees non-zero fields
    function automatic logic [31:0] mkcmd(input logic [4:0] op,
                                          input logic [2:0] size,
                                          input logic [7:0] len,
                                          input logic       eom);
        return {5'd3, 2'd0, 1'b0, 1'b0, eom, 2'd0, 4'd2, len, size, op};
    endfunction

    function automatic logic [63:0] dat(input int k);
        return {8{8'(8'h10 + k)}};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] c, input logic [63:0] d,
                        input logic [63:0] s, input logic [255:0] x);
        exp_t e;
        e.cmd = c; e.dst = d; e.src = s; e.data = x;
        sb.push_back(e);
    endtask

    task automatic send(input logic [31:0] c, input logic [63:0] d,
                        input logic [63:0] s, input logic [63:0] x);
        int n;
        umi_in_valid   = 1'b1;
        umi_in_cmd     = c;
        umi_in_dstaddr = d;
        umi_in_srcaddr = s;
        umi_in_data    = x;
        n = 0;
        @(negedge clk);
        while (!umi_in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!umi_in_ready) chk("send_timeout", umi_in_ready, 1);
        @(posedge clk);
        #1;
        umi_in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({"drain_", tag}, sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (stall_on && umi_in_valid && !umi_in_ready) stalls++;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset && umi_out_valid && umi_out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", umi_out_valid, 0);
            end else begin
                e = sb.pop_front();
                chk("out_cmd", umi_out_cmd, e.cmd);
                chk("out_dst", umi_out_dstaddr, e.dst);
                chk("out_src", umi_out_srcaddr, e.src);
                chk("out_data", umi_out_data, e.data);
            end
        end
    end

    initial begin
        int n;
        // reset values and ready hold-off
        #1 reset = 1'b1;
        #2;
        chk("rst_out_valid", umi_out_valid, 0);
        chk("rst_in_ready", umi_in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd", umi_out_cmd, 0);
        chk("rst_dst", umi_out_dstaddr, 0);
        chk("rst_src", umi_out_srcaddr, 0);
        chk("rst_data", umi_out_data, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("ready_rel0", umi_in_ready, 0);
        @(posedge clk); #1;
        chk("ready_rel1", umi_in_ready, 0);
        @(posedge clk); #1;
        chk("ready_rel2", umi_in_ready, 1);

        // eight contiguous posted writes -> two 32-byte packets
        push(mkcmd(5'h05, 3'd3, 8'd3, 1'b0), 64'h1000, 64'h8000,
             {dat(3), dat(2), dat(1), dat(0)});
        push(mkcmd(5'h05, 3'd3, 8'd3, 1'b1), 64'h1020, 64'h8020,
             {dat(7), dat(6), dat(5), dat(4)});
        for (int k = 0; k < 8; k++)
            send(mkcmd(5'h05, 3'd3, 8'd0, k == 7), 64'h1000 + 64'(8 * k),
                 64'h8000 + 64'(8 * k), dat(k));
        drain("eight");

        // non-contiguous address breaks the accumulation
        push(mkcmd(5'h05, 3'd3, 8'd1, 1'b0), 64'h2000, 64'h9000,
             {128'd0, dat(1), dat(0)});
        push(mkcmd(5'h05, 3'd3, 8'd0, 1'b1), 64'h3000, 64'h9800,
             {192'd0, dat(2)});
        stalls = 0;
        stall_on = 1'b1;
        send(mkcmd(5'h05, 3'd3, 8'd0, 1'b0), 64'h2000, 64'h9000, dat(0));
        send(mkcmd(5'h05, 3'd3, 8'd0, 1'b0), 64'h2008, 64'h9008, dat(1));
        send(mkcmd(5'h05, 3'd3, 8'd0, 1'b1), 64'h3000, 64'h9800, dat(2));
        stall_on = 1'b0;
        chk("noncontig_stall", stalls, 1);
        drain("noncontig");

        // idle timeout flushes a lone packet
        push(mkcmd(5'h05, 3'd3, 8'd0, 1'b0), 64'h4000, 64'hA000,
             {192'd0, dat(9)});
        send(mkcmd(5'h05, 3'd3, 8'd0, 1'b0), 64'h4000, 64'hA000, dat(9));
        n = 0;
        while (!umi_out_valid && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk("timeout_idle", n, 16);
        drain("timeout");

        // flush with three packets held; compatible input waits
        push(mkcmd(5'h05, 3'd3, 8'd2, 1'b0), 64'h5000, 64'hB000,
             {64'd0, dat(2), dat(1), dat(0)});
        push(mkcmd(5'h05, 3'd3, 8'd0, 1'b1), 64'h5018, 64'hB018,
             {192'd0, dat(3)});
        for (int k = 0; k < 3; k++)
            send(mkcmd(5'h05, 3'd3, 8'd0, 1'b0), 64'h5000 + 64'(8 * k),
                 64'hB000 + 64'(8 * k), dat(k));
        flush          = 1'b1;
        umi_in_valid   = 1'b1;
        umi_in_cmd     = mkcmd(5'h05, 3'd3, 8'd0, 1'b1);
        umi_in_dstaddr = 64'h5018;
        umi_in_srcaddr = 64'hB018;
        umi_in_data    = dat(3);
        @(negedge clk);
        chk("flush_hold", umi_in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_emit", umi_out_valid, 1);
        send(mkcmd(5'h05, 3'd3, 8'd0, 1'b1), 64'h5018, 64'hB018, dat(3));
        drain("flush");

        // merge disabled, output back-pressure holds fields
        merge_en = 1'b0;
        umi_out_ready = 1'b0;
        for (int k = 0; k < 4; k++)
            push(mkcmd(5'h05, 3'd3, 8'd0, 1'b0), 64'h5800 + 64'(8 * k),
                 64'hC000 + 64'(8 * k), {192'd0, dat(k)});
        send(mkcmd(5'h05, 3'd3, 8'd0, 1'b0), 64'h5800, 64'hC000, dat(0));
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", umi_out_valid, 1);
            chk("stall_cmd", umi_out_cmd, mkcmd(5'h05, 3'd3, 8'd0, 1'b0));
            chk("stall_dst", umi_out_dstaddr, 64'h5800);
            chk("stall_data", umi_out_data, {192'd0, dat(0)});
            @(posedge clk); #1;
        end
        umi_out_ready = 1'b1;
        for (int k = 1; k < 4; k++)
            send(mkcmd(5'h05, 3'd3, 8'd0, 1'b0), 64'h5800 + 64'(8 * k),
                 64'hC000 + 64'(8 * k), dat(k));
        drain("nomerge");
        merge_en = 1'b1;

        // reset mid-accumulation discards the partial packet
        send(mkcmd(5'h05, 3'd3, 8'd0, 1'b0), 64'h6000, 64'hD000, dat(4));
        send(mkcmd(5'h05, 3'd3, 8'd0, 1'b0), 64'h6008, 64'hD008, dat(5));
        chk("pre_rst_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", umi_out_valid, 0);
        chk("mid_rst_ready", umi_in_ready, 0);
        chk("mid_rst_cmd", umi_out_cmd, 0);
        chk("mid_rst_data", umi_out_data, 0);
        @(posedge clk); #1 reset = 1'b0;
        push(mkcmd(5'h05, 3'd3, 8'd0, 1'b1), 64'h7000, 64'hE000,
             {192'd0, dat(6)});
        send(mkcmd(5'h05, 3'd3, 8'd0, 1'b1), 64'h7000, 64'hE000, dat(6));
        drain("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
